// File: rtl/ascon_pack.sv
// Shared ASCON types, round constants and small helpers for the permutation engine.
package ascon_pack;

  // Five 64-bit words; word 0 (x0) is the most significant in the flat view.
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perm_state_t;

  // c_r = {15-r, r} for r = 0..11
  localparam logic [7:0] ROUND_CST [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Round constant lookup; indices past the table return zero (never applied anyway).
  function automatic logic [7:0] round_cst(input logic [3:0] r);
    if (r < 4'd12) begin
      return ROUND_CST[r];
    end else begin
      return 8'h00;
    end
  endfunction

  // 64-bit right rotate by a nonzero amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned amt);
    return (x >> amt) | (x << (32'd64 - amt));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear diffusion.
// When enable_i is low the state passes through unchanged.
module ascon_round
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  input  logic        enable_i,
  output type_state   state_o
);

  type_state   add_s;
  type_state   sbox_s;
  type_state   lin_s;
  logic [63:0] x0_s, x1_s, x2_s, x3_s, x4_s;
  logic [63:0] t0_s, t1_s, t2_s, t3_s, t4_s;
  logic [63:0] a0_s, a1_s, a2_s, a3_s, a4_s;

  // Compose pC, pS and pL, then select round output or bypass.
  always_comb begin
    add_s        = state_i;
    add_s[2][7:0] = state_i[2][7:0] ^ round_cst(round_i);

    x0_s = add_s[0] ^ add_s[4];
    x1_s = add_s[1];
    x2_s = add_s[2] ^ add_s[1];
    x3_s = add_s[3];
    x4_s = add_s[4] ^ add_s[3];

    t0_s = ~x0_s & x1_s;
    t1_s = ~x1_s & x2_s;
    t2_s = ~x2_s & x3_s;
    t3_s = ~x3_s & x4_s;
    t4_s = ~x4_s & x0_s;

    a0_s = x0_s ^ t1_s;
    a1_s = x1_s ^ t2_s;
    a2_s = x2_s ^ t3_s;
    a3_s = x3_s ^ t4_s;
    a4_s = x4_s ^ t0_s;

    sbox_s[0] = a0_s ^ a4_s;
    sbox_s[1] = a1_s ^ a0_s;
    sbox_s[2] = ~a2_s;
    sbox_s[3] = a3_s ^ a2_s;
    sbox_s[4] = a4_s;

    lin_s[0] = sbox_s[0] ^ ror64(sbox_s[0], 32'd19) ^ ror64(sbox_s[0], 32'd28);
    lin_s[1] = sbox_s[1] ^ ror64(sbox_s[1], 32'd61) ^ ror64(sbox_s[1], 32'd39);
    lin_s[2] = sbox_s[2] ^ ror64(sbox_s[2], 32'd1)  ^ ror64(sbox_s[2], 32'd6);
    lin_s[3] = sbox_s[3] ^ ror64(sbox_s[3], 32'd10) ^ ror64(sbox_s[3], 32'd17);
    lin_s[4] = sbox_s[4] ^ ror64(sbox_s[4], 32'd7)  ^ ror64(sbox_s[4], 32'd41);

    if (enable_i) begin
      state_o = lin_s;
    end else begin
      state_o = state_i;
    end
  end

endmodule

// File: rtl/permutation_engine.sv
// Iterative ASCON permutation engine: runs 1..12 rounds, UNROLL rounds per clock,
// with a start/ready/done handshake and a registered result.
module permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic [3:0]  nb_rounds_i,
  input  type_state   state_i,
  output logic        ready_o,
  output logic        done_o,
  output type_state   state_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 ||
        UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
    $error("permutation_engine: UNROLL must be one of 1,2,3,4,6,12");
  end

  perm_state_t fsm_q;
  logic [3:0]  rnd_q;
  type_state   state_q;
  logic        done_q;
  logic        ready_q;

  logic [3:0]  n_sat_s;
  logic [4:0]  rnd_sum_s;
  type_state   chain_s [0:UNROLL];

  assign chain_s[0] = state_q;

  // Chain of round slots; a slot whose index has run past the last round is bypassed.
  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [4:0] idx_s;
    assign idx_s = {1'b0, rnd_q} + 5'(k);
    ascon_round u_round (
      .state_i  (chain_s[k]),
      .round_i  (idx_s[3:0]),
      .enable_i (idx_s < 5'(MAX_ROUNDS)),
      .state_o  (chain_s[k+1])
    );
  end

  // Saturate the requested round count and precompute the next round index.
  always_comb begin
    if (nb_rounds_i > 4'(MAX_ROUNDS)) begin
      n_sat_s = 4'(MAX_ROUNDS);
    end else begin
      n_sat_s = nb_rounds_i;
    end
    rnd_sum_s = {1'b0, rnd_q} + 5'(UNROLL);
  end

  // Control FSM, round counter, state register and registered handshake outputs.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            rnd_q   <= 4'(MAX_ROUNDS) - n_sat_s;
            ready_q <= 1'b0;
            if (n_sat_s == 4'd0) begin
              fsm_q  <= DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= RUN;
              done_q <= 1'b0;
            end
          end else begin
            done_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= chain_s[UNROLL];
          if (rnd_sum_s >= 5'(MAX_ROUNDS)) begin
            rnd_q  <= 4'(MAX_ROUNDS);
            fsm_q  <= DONE;
            done_q <= 1'b1;
          end else begin
            rnd_q  <= rnd_sum_s[3:0];
          end
        end
        DONE: begin
          fsm_q   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          fsm_q   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule
